serial_ctrl_mc: RTL

- Parametrised multi-channel successor to the single-wire serial controller.
- One bidirectional half-duplex line carries framed transfers: start bit, opcode, channel index, controller ACK/NACK, then an optional data phase.
- Each of N_CH channels owns an internal DATA_LEN shift register and a latched parallel output.
- Adds over the previous generation: channel addressing, handshake acknowledge, read-back of parallel inputs, rejection of illegal frames, and protection against a stuck-high line.

---
 rtl/serial_ctrl_mc.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_ctrl_mc.sv
// rtl/serial_ctrl_mc.sv - multi-channel half-duplex serial controller
// Framed transfers on one line: start, opcode, channel, ACK/NACK, optional data phase.
module serial_ctrl_mc #(
   parameter int DATA_LEN = 8,
   parameter int N_CH     = 4,
   parameter int CMD_LEN  = 3,
   localparam int CH_BITS = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   inout  wire                      data_inout,
   input  logic [N_CH*DATA_LEN-1:0] bit_in,
   output logic [N_CH*DATA_LEN-1:0] bit_out,
   output logic                     busy,
   output logic                     nack
);

   localparam int HDR_LEN = CMD_LEN + CH_BITS;
   localparam int CNT_MAX = (DATA_LEN > HDR_LEN) ? DATA_LEN : HDR_LEN;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CMD_LEN-1:0] OP_WRITE   = CMD_LEN'(1);
   localparam logic [CMD_LEN-1:0] OP_READ    = CMD_LEN'(2);
   localparam logic [CMD_LEN-1:0] OP_UPDATE  = CMD_LEN'(3);
   localparam logic [CMD_LEN-1:0] OP_CLEAR   = CMD_LEN'(4);
   localparam logic [CMD_LEN-1:0] OP_CAPTURE = CMD_LEN'(5);

   typedef enum logic [3:0] {
      ARM, IDLE, RX_HDR, TURN1, ACK, TURN2, RX_DATA, TX_DATA, EXEC
   } state_t;

   state_t                            state_q, state_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [HDR_LEN-1:0]                hdr_q, hdr_d;
   logic                              ok_q, ok_d;
   logic [N_CH-1:0][DATA_LEN-1:0]     sr_q, sr_d;
   logic [N_CH-1:0][DATA_LEN-1:0]     bout_q, bout_d;
   logic                              drv_en_q, drv_en_d;
   logic                              drv_val_q, drv_val_d;
   logic                              nack_q, nack_d;

   logic                              line_s;
   logic [CMD_LEN-1:0]                op;
   logic [CH_BITS-1:0]                ch;
   logic                              legal;

   // Line is only ever driven from registers, so release on reset is immediate.
   assign data_inout = drv_en_q ? drv_val_q : 1'bz;
   assign line_s     = data_inout;

   assign op    = hdr_q[HDR_LEN-1 -: CMD_LEN];
   assign ch    = hdr_q[CH_BITS-1:0];
   assign legal = (op inside {OP_WRITE, OP_READ, OP_UPDATE, OP_CLEAR, OP_CAPTURE})
                  && (int'(ch) < N_CH);

   assign bit_out = bout_q;
   assign busy    = !(state_q inside {ARM, IDLE});
   assign nack    = nack_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ARM;
         cnt_q     <= '0;
         hdr_q     <= '0;
         ok_q      <= 1'b0;
         sr_q      <= '0;
         bout_q    <= '0;
         drv_en_q  <= 1'b0;
         drv_val_q <= 1'b0;
         nack_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hdr_q     <= hdr_d;
         ok_q      <= ok_d;
         sr_q      <= sr_d;
         bout_q    <= bout_d;
         drv_en_q  <= drv_en_d;
         drv_val_q <= drv_val_d;
         nack_q    <= nack_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hdr_d     = hdr_q;
      ok_d      = ok_q;
      sr_d      = sr_q;
      bout_d    = bout_q;
      drv_en_d  = 1'b0;
      drv_val_d = 1'b0;
      nack_d    = 1'b0;

      case (state_q)
         // A line stuck at 1 parks here until it has been seen low once.
         ARM: begin
            if (!line_s) state_d = IDLE;
         end
         IDLE: begin
            if (line_s) state_d = RX_HDR;
         end
         RX_HDR: begin
            hdr_d = {hdr_q[HDR_LEN-2:0], line_s};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(HDR_LEN - 1)) state_d = TURN1;
         end
         TURN1: begin
            ok_d      = legal;
            drv_en_d  = 1'b1;
            drv_val_d = legal;
            nack_d    = !legal;
            state_d   = ACK;
         end
         ACK: begin
            state_d = TURN2;
         end
         TURN2: begin
            if (!ok_q) begin
               state_d = ARM;
            end else if (op == OP_WRITE) begin
               state_d = RX_DATA;
            end else if (op == OP_READ) begin
               state_d   = TX_DATA;
               drv_en_d  = 1'b1;
               drv_val_d = sr_q[ch][DATA_LEN-1];
            end else begin
               state_d = EXEC;
            end
         end
         RX_DATA: begin
            sr_d[ch] = {sr_q[ch][DATA_LEN-2:0], line_s};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_LEN - 1)) state_d = ARM;
         end
         // Rotate rather than shift so a read leaves the register intact.
         TX_DATA: begin
            sr_d[ch] = {sr_q[ch][DATA_LEN-2:0], sr_q[ch][DATA_LEN-1]};
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_LEN - 1)) begin
               state_d = ARM;
            end else begin
               drv_en_d  = 1'b1;
               drv_val_d = sr_q[ch][DATA_LEN-2];
            end
         end
         EXEC: begin
            case (op)
               OP_UPDATE:  bout_d[ch] = sr_q[ch];
               OP_CLEAR:   sr_d[ch]   = '0;
               OP_CAPTURE: sr_d[ch]   = bit_in[int'(ch)*DATA_LEN +: DATA_LEN];
               default:    ;
            endcase
            state_d = ARM;
         end
         default: state_d = ARM;
      endcase

      if (state_d != state_q) cnt_d = '0;
   end

endmodule
